// File: rtl/pc_seq_pkg.sv
// Shared opcodes and FSM state encoding for the PC sequencer.
package pc_seq_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_JNP  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } pc_seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// ROM/PC-side bus of the sequencer: master is the sequencer, slave is the PC/ROM environment.
interface pc_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int CNT_W = 8
);
  logic             start;
  logic [1:0]       p;
  logic [3:0]       instr;
  logic             inc;
  logic             jnp;
  logic             r2;
  logic             i1;
  logic             i0;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] retired;

  modport master (
    input  start, p, instr,
    output inc, jnp, r2, i1, i0, busy, done, retired
  );

  modport slave (
    output start, p, instr,
    input  inc, jnp, r2, i1, i0, busy, done, retired
  );
endinterface

// File: rtl/pc_seq_decode.sv
// Combinational instruction decode: next strobes, next r2, jump target and halt; no state, no latency.
module pc_seq_decode
  import pc_seq_pkg::*;
(
  input  logic [1:0] op_i,
  input  logic [1:0] imm_i,
  input  logic       r2_i,
  output logic       inc_o,
  output logic       jnp_o,
  output logic       r2_o,
  output logic [1:0] tgt_o,
  output logic       halt_o
);

  always_comb begin
    inc_o  = 1'b0;
    jnp_o  = 1'b0;
    r2_o   = r2_i;
    tgt_o  = 2'b00;
    halt_o = 1'b0;
    case (op_i)
      OP_NOP: inc_o = 1'b1;
      OP_SET: begin
        r2_o  = imm_i[0];
        inc_o = 1'b1;
      end
      OP_JNP: begin
        // target only driven when the jump is taken so i1:i0 reads 00 otherwise
        if (!r2_i) begin
          jnp_o = 1'b1;
          tgt_o = imm_i;
        end else begin
          inc_o = 1'b1;
        end
      end
      OP_HALT: halt_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// FETCH/EXEC control FSM for the 2-bit PC; strobes are registered so they are high during EXEC.
// Build option PC_SEQ_STEP_EN adds a `step` input gating FETCH->EXEC.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef PC_SEQ_STEP_EN
  input  logic                 step,
`endif
  pc_sequencer_if.master       bus
);

  pc_seq_state_t    state_q, state_d;
  logic [3:0]       ir_q, ir_d;
  logic [1:0]       pcs_q, pcs_d;
  logic             inc_q, inc_d;
  logic             jnp_q, jnp_d;
  logic             r2_q, r2_d;
  logic [1:0]       tgt_q, tgt_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [3:0]       dec_ir;
  logic             dec_inc, dec_jnp, dec_r2, dec_halt;
  logic [1:0]       dec_tgt;
  logic             fetch_go;

`ifdef PC_SEQ_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  // In FETCH the strobes for the coming EXEC are decoded from live ROM data.
  assign dec_ir = (state_q == FETCH) ? bus.instr : ir_q;

  pc_seq_decode u_decode (
    .op_i   (dec_ir[3:2]),
    .imm_i  (dec_ir[1:0]),
    .r2_i   (r2_q),
    .inc_o  (dec_inc),
    .jnp_o  (dec_jnp),
    .r2_o   (dec_r2),
    .tgt_o  (dec_tgt),
    .halt_o (dec_halt)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    pcs_d     = pcs_q;
    inc_d     = 1'b0;
    jnp_d     = 1'b0;
    tgt_d     = 2'b00;
    r2_d      = r2_q;
    retired_d = retired_q;
    case (state_q)
      IDLE: if (bus.start) state_d = FETCH;
      FETCH: begin
        ir_d  = bus.instr;
        pcs_d = bus.p;
        if (fetch_go) begin
          state_d = EXEC;
          inc_d   = dec_inc;
          jnp_d   = dec_jnp;
          tgt_d   = dec_tgt;
        end
      end
      EXEC: begin
        r2_d = dec_r2;
        if (retired_q != {CNT_W{1'b1}}) retired_d = retired_q + CNT_W'(1);
        state_d = dec_halt ? HALTED : FETCH;
      end
      HALTED: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ir_q      <= 4'b0000;
      pcs_q     <= 2'b00;
      inc_q     <= 1'b0;
      jnp_q     <= 1'b0;
      r2_q      <= 1'b0;
      tgt_q     <= 2'b00;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      pcs_q     <= pcs_d;
      inc_q     <= inc_d;
      jnp_q     <= jnp_d;
      r2_q      <= r2_d;
      tgt_q     <= tgt_d;
      retired_q <= retired_d;
    end
  end

  // The PC must not move while an instruction is between FETCH and the end of EXEC.
  pc_stable_in_exec: assert property (@(posedge clk) disable iff (rst)
    (state_q == EXEC) |-> (bus.p == pcs_q));

  assign bus.inc     = inc_q;
  assign bus.jnp     = jnp_q;
  assign bus.r2      = r2_q;
  assign bus.i1      = tgt_q[1];
  assign bus.i0      = tgt_q[0];
  assign bus.retired = retired_q;
  assign bus.busy    = (state_q == FETCH) || (state_q == EXEC);
  assign bus.done    = (state_q == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench: sequencer + 2-bit PC model + 4-entry ROM; immediate assertions at each check point.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic       clk;
  logic       rst;
  logic [1:0] pc;
  logic [3:0] rom [4];
  int         total;
  int         bad;
`ifdef PC_SEQ_STEP_EN
  logic       step;
`endif

  pc_sequencer_if #(.CNT_W(8)) bus ();

  pc_sequencer #(.CNT_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef PC_SEQ_STEP_EN
    .step (step),
`endif
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter: load wins over increment, wraps 3->0, reset with the sequencer.
  always_ff @(posedge clk) begin
    if (rst)          pc <= 2'b00;
    else if (bus.jnp) pc <= {bus.i1, bus.i0};
    else if (bus.inc) pc <= pc + 2'd1;
  end

  assign bus.p     = pc;
  assign bus.instr = rom[pc];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every strobe/status output plus the PC in one go.
  task automatic chk_all(input string tag, input logic e_inc, input logic e_jnp, input logic e_r2,
                         input logic [1:0] e_tgt, input logic e_busy, input logic e_done,
                         input logic [1:0] e_pc);
    chk({tag, ".inc"},  bus.inc, e_inc);
    chk({tag, ".jnp"},  bus.jnp, e_jnp);
    chk({tag, ".r2"},   bus.r2, e_r2);
    chk({tag, ".tgt"},  {bus.i1, bus.i0}, e_tgt);
    chk({tag, ".busy"}, bus.busy, e_busy);
    chk({tag, ".done"}, bus.done, e_done);
    chk({tag, ".pc"},   pc, e_pc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.start = 1'b0;
`ifdef PC_SEQ_STEP_EN
    step = 1'b1;
`endif
    rom[0] = 4'b0000; rom[1] = 4'b0000; rom[2] = 4'b0000; rom[3] = 4'b1100;

    // Reset then idle for 5 cycles.
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    chk_all("idle", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
    chk("idle.state", dut.state_q, IDLE);
    chk("idle.retired", bus.retired, 0);
    chk("idle.ir", dut.ir_q, 0);

    // Linear run NOP,NOP,NOP,HALT with start held high throughout.
    bus.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all($sformatf("lin.fetch%0d", k), 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'(k));
      tick();
      chk_all($sformatf("lin.exec%0d", k), 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'(k));
    end
    tick();
    chk_all("lin.fetch_halt", 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'd3);
    tick();
    chk_all("lin.exec_halt", 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'd3);
    chk("lin.retired_in_halt_exec", bus.retired, 3);
    tick();
    chk_all("lin.halted", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'd3);
    chk("lin.retired", bus.retired, 4);
    for (int i = 0; i < 6; i++) tick();
    chk_all("lin.sticky", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'd3);
    chk("lin.sticky_retired", bus.retired, 4);

    // Taken jump: SET 0, JNP 11, NOP, HALT.
    rom[0] = 4'b0100; rom[1] = 4'b1011; rom[2] = 4'b0000; rom[3] = 4'b1100;
    do_reset();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_all("tj.fetch_set", 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'd0);
    tick();
    chk_all("tj.exec_set", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'd0);
    tick();
    chk_all("tj.fetch_jnp", 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'd1);
    tick();
    chk_all("tj.exec_jnp", 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 2'd1);
    tick();
    chk_all("tj.fetch_halt", 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'd3);
    tick();
    tick();
    chk_all("tj.halted", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'd3);
    chk("tj.retired", bus.retired, 3);

    // Untaken jump and wrap: SET 1, NOP, NOP, JNP 00 loops forever.
    rom[0] = 4'b0101; rom[1] = 4'b0000; rom[2] = 4'b0000; rom[3] = 4'b1000;
    do_reset();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk_all("uj.exec_set", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'd0);
    tick();
    chk_all("uj.fetch1", 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 2'd1);
    for (int i = 0; i < 4; i++) tick();
    chk_all("uj.fetch_jnp", 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 2'd3);
    tick();
    chk_all("uj.exec_jnp", 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 2'd3);
    tick();
    chk_all("uj.wrap", 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0);
    chk("uj.retired4", bus.retired, 4);
    for (int i = 0; i < 600; i++) tick();
    chk("uj.retired_sat", bus.retired, 255);
    for (int i = 0; i < 20; i++) tick();
    chk("uj.retired_hold", bus.retired, 255);
    chk("uj.busy", bus.busy, 1'b1);

    // Reset during the EXEC of a taken JNP.
    rom[0] = 4'b0100; rom[1] = 4'b1011; rom[2] = 4'b0000; rom[3] = 4'b1100;
    do_reset();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk_all("rm.exec_jnp", 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 2'd1);
    chk("rm.retired_before", bus.retired, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("rm.after", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0);
    chk("rm.state", dut.state_q, IDLE);
    chk("rm.retired", bus.retired, 0);
    tick();
    chk("rm.stay_idle", dut.state_q, IDLE);

`ifdef PC_SEQ_STEP_EN
    // Single step: FETCH holds until step, then exactly one EXEC.
    rom[0] = 4'b0000; rom[1] = 4'b0000; rom[2] = 4'b0000; rom[3] = 4'b1100;
    step = 1'b0;
    do_reset();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_all($sformatf("st.wait%0d", i), 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'd0);
      chk($sformatf("st.state%0d", i), dut.state_q, FETCH);
      tick();
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    chk_all("st.exec", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'd0);
    tick();
    chk_all("st.next_fetch", 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'd1);
    tick();
    tick();
    chk_all("st.held", 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'd1);
    chk("st.retired", bus.retired, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
